// File: rtl/unified_mem_arbiter.sv
// Arbitrates one single-port synchronous-read BRAM between fetch, data and UART programmer.
// Fetch/data conflicts cost one hold cycle; read data is re-timed to plain one-cycle latency.
module unified_mem_arbiter #(
    parameter int unsigned MEM_AW  = 12,
    parameter logic [3:0]  PROG_BE = 4'b1111
) (
    input  logic              clk,
    input  logic              Rst,
    input  logic              imem_en,
    input  logic [31:0]       imem_addr,
    output logic [31:0]       imem_dout,
    input  logic              dmem_rea,
    input  logic              dmem_wea,
    input  logic [3:0]        dmem_en,
    input  logic [31:0]       dmem_addr,
    input  logic [31:0]       dmem_din,
    output logic [31:0]       dmem_dout,
    input  logic              prog_ena,
    input  logic              prog_we,
    input  logic [31:0]       prog_din,
    output logic [MEM_AW-1:0] prog_count,
    output logic              mem_hold,
    output logic              ram_en,
    output logic [3:0]        ram_we,
    output logic [MEM_AW-1:0] ram_addr,
    output logic [31:0]       ram_din,
    input  logic [31:0]       ram_dout
);

    typedef enum logic [1:0] {StRun, StFetch, StProg} state_e;

    state_e            state_q, state_d;
    logic [MEM_AW-1:0] prog_count_q, prog_count_d;
    logic [31:0]       ibuf_q, ibuf_d;
    logic [31:0]       dbuf_q, dbuf_d;
    logic              gi_q, gi_d;
    logic              gd_q, gd_d;
    logic              dsel_buf_q, dsel_buf_d;

    logic              dreq;
    logic [MEM_AW-1:0] iword;
    logic [MEM_AW-1:0] dword;
    logic              unused_addr_bits;

    assign dreq  = (dmem_rea | dmem_wea) & (dmem_en != 4'b0000);
    assign iword = imem_addr[MEM_AW+1:2];
    assign dword = dmem_addr[MEM_AW+1:2];
    assign unused_addr_bits = ^{imem_addr[31:MEM_AW+2], imem_addr[1:0],
                                dmem_addr[31:MEM_AW+2], dmem_addr[1:0]};

    always_comb begin
        state_d      = state_q;
        prog_count_d = prog_count_q;
        gi_d         = 1'b0;
        gd_d         = 1'b0;
        dsel_buf_d   = 1'b0;
        ibuf_d       = gi_q ? ram_dout : ibuf_q;
        dbuf_d       = gd_q ? ram_dout : dbuf_q;
        mem_hold     = 1'b0;
        ram_en       = 1'b0;
        ram_we       = 4'b0000;
        ram_addr     = iword;
        ram_din      = dmem_din;

        unique case (state_q)
            StRun: begin
                if (prog_ena) begin
                    state_d      = StProg;
                    mem_hold     = 1'b1;
                    prog_count_d = '0;
                    if (prog_we) begin
                        ram_en       = 1'b1;
                        ram_we       = PROG_BE;
                        ram_addr     = '0;
                        ram_din      = prog_din;
                        prog_count_d = MEM_AW'(1);
                    end
                end else if (dreq) begin
                    // Data wins; a conflicting fetch is replayed from FETCH next cycle.
                    ram_en   = 1'b1;
                    ram_we   = dmem_wea ? dmem_en : 4'b0000;
                    ram_addr = dword;
                    gd_d     = dmem_rea;
                    if (imem_en) begin
                        mem_hold = 1'b1;
                        state_d  = StFetch;
                    end
                end else if (imem_en) begin
                    ram_en = 1'b1;
                    gi_d   = 1'b1;
                end
            end
            StFetch: begin
                // Data result lands in dbuf here while the fetch takes the RAM.
                ram_en       = 1'b1;
                gi_d         = 1'b1;
                dsel_buf_d   = 1'b1;
                prog_count_d = '0;
                state_d      = prog_ena ? StProg : StRun;
            end
            StProg: begin
                mem_hold = 1'b1;
                if (!prog_ena) begin
                    state_d      = StRun;
                    prog_count_d = '0;
                end else if (prog_we) begin
                    ram_en       = 1'b1;
                    ram_we       = PROG_BE;
                    ram_addr     = prog_count_q;
                    ram_din      = prog_din;
                    prog_count_d = prog_count_q + MEM_AW'(1);
                end
            end
            default: state_d = StRun;
        endcase

        if (Rst) begin
            mem_hold = 1'b0;
            ram_en   = 1'b0;
            ram_we   = 4'b0000;
        end
    end

    always_ff @(posedge clk) begin
        if (Rst) begin
            state_q      <= StRun;
            prog_count_q <= '0;
            ibuf_q       <= '0;
            dbuf_q       <= '0;
            gi_q         <= 1'b0;
            gd_q         <= 1'b0;
            dsel_buf_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            prog_count_q <= prog_count_d;
            ibuf_q       <= ibuf_d;
            dbuf_q       <= dbuf_d;
            gi_q         <= gi_d;
            gd_q         <= gd_d;
            dsel_buf_q   <= dsel_buf_d;
        end
    end

    assign prog_count = prog_count_q;
    assign imem_dout  = gi_q ? ram_dout : ibuf_q;
    assign dmem_dout  = (gd_q && !dsel_buf_q) ? ram_dout : dbuf_q;

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Self-checking bench: directed scenarios plus randomized core traffic against a
// transaction-level memory model; a second instance with MEM_AW=2 covers address wrap.
module tb_unified_mem_arbiter;

    logic        clk = 1'b0;
    logic        Rst;
    logic        imem_en, dmem_rea, dmem_wea, prog_ena, prog_we;
    logic [31:0] imem_addr, dmem_addr, dmem_din, prog_din;
    logic [3:0]  dmem_en;
    logic [31:0] imem_dout, dmem_dout, ram_din;
    logic [31:0] ram_dout = 32'h0;
    logic [11:0] prog_count, ram_addr;
    logic        mem_hold, ram_en;
    logic [3:0]  ram_we;

    logic        p2_ena, p2_we;
    logic [31:0] p2_din;
    logic [31:0] b_imem_dout, b_dmem_dout, b_ram_din;
    logic [31:0] b_ram_dout = 32'h0;
    logic [1:0]  b_prog_count, b_ram_addr;
    logic        b_mem_hold, b_ram_en;
    logic [3:0]  b_ram_we;

    logic [31:0] mem  [0:4095];
    logic [31:0] mem2 [0:3];
    logic [31:0] ref_mem [0:31];

    int nchk = 0;
    int nerr = 0;

    always #5 clk = ~clk;

    unified_mem_arbiter #(.MEM_AW(12), .PROG_BE(4'b1111)) dut (
        .clk(clk), .Rst(Rst),
        .imem_en(imem_en), .imem_addr(imem_addr), .imem_dout(imem_dout),
        .dmem_rea(dmem_rea), .dmem_wea(dmem_wea), .dmem_en(dmem_en),
        .dmem_addr(dmem_addr), .dmem_din(dmem_din), .dmem_dout(dmem_dout),
        .prog_ena(prog_ena), .prog_we(prog_we), .prog_din(prog_din),
        .prog_count(prog_count), .mem_hold(mem_hold),
        .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr),
        .ram_din(ram_din), .ram_dout(ram_dout)
    );

    unified_mem_arbiter #(.MEM_AW(2), .PROG_BE(4'b1111)) dut2 (
        .clk(clk), .Rst(Rst),
        .imem_en(1'b0), .imem_addr(32'h0), .imem_dout(b_imem_dout),
        .dmem_rea(1'b0), .dmem_wea(1'b0), .dmem_en(4'h0),
        .dmem_addr(32'h0), .dmem_din(32'h0), .dmem_dout(b_dmem_dout),
        .prog_ena(p2_ena), .prog_we(p2_we), .prog_din(p2_din),
        .prog_count(b_prog_count), .mem_hold(b_mem_hold),
        .ram_en(b_ram_en), .ram_we(b_ram_we), .ram_addr(b_ram_addr),
        .ram_din(b_ram_din), .ram_dout(b_ram_dout)
    );

    // Read-first byte-writable BRAMs behind each instance.
    always @(posedge clk) begin
        if (ram_en) begin
            ram_dout <= mem[ram_addr];
            for (int b = 0; b < 4; b++)
                if (ram_we[b]) mem[ram_addr][8*b +: 8] <= ram_din[8*b +: 8];
        end
        if (b_ram_en) begin
            b_ram_dout <= mem2[b_ram_addr];
            for (int b = 0; b < 4; b++)
                if (b_ram_we[b]) mem2[b_ram_addr][8*b +: 8] <= b_ram_din[8*b +: 8];
        end
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        imem_en = 0; imem_addr = 0; dmem_rea = 0; dmem_wea = 0; dmem_en = 0;
        dmem_addr = 0; dmem_din = 0; prog_ena = 0; prog_we = 0; prog_din = 0;
        p2_ena = 0; p2_we = 0; p2_din = 0;
    endtask

    task automatic test_reset();
        Rst = 1; idle();
        @(negedge clk);
        nchk++; if (mem_hold !== 1'b0) begin nerr++; $display("FAIL reset_hold got %b want 0", mem_hold); end
        nchk++; if (ram_en !== 1'b0) begin nerr++; $display("FAIL reset_ram_en got %b want 0", ram_en); end
        nchk++; if (ram_we !== 4'h0) begin nerr++; $display("FAIL reset_ram_we got %h want 0", ram_we); end
        next_cycle(); Rst = 0;
        @(negedge clk);
        nchk++; if (imem_dout !== 32'h0) begin nerr++; $display("FAIL reset_imem got %h want 0", imem_dout); end
        nchk++; if (dmem_dout !== 32'h0) begin nerr++; $display("FAIL reset_dmem got %h want 0", dmem_dout); end
        nchk++; if (prog_count !== 12'h0) begin nerr++; $display("FAIL reset_pc got %h want 0", prog_count); end
        nchk++; if (b_prog_count !== 2'h0) begin nerr++; $display("FAIL reset_pc2 got %h want 0", b_prog_count); end
        next_cycle();
    endtask

    task automatic test_fetch();
        imem_en = 1; imem_addr = 32'h14;
        @(negedge clk);
        nchk++; if (ram_addr !== 12'd5) begin nerr++; $display("FAIL fetch_addr got %0d want 5", ram_addr); end
        nchk++; if (mem_hold !== 1'b0) begin nerr++; $display("FAIL fetch_hold got %b want 0", mem_hold); end
        nchk++; if (ram_en !== 1'b1 || ram_we !== 4'h0) begin nerr++; $display("FAIL fetch_en got %b/%h want 1/0", ram_en, ram_we); end
        next_cycle(); idle();
        @(negedge clk);
        nchk++; if (imem_dout !== 32'h00500093) begin nerr++; $display("FAIL fetch_data got %h want 00500093", imem_dout); end
        next_cycle();
    endtask

    task automatic test_conflict_load();
        dmem_rea = 1; dmem_en = 4'hF; dmem_addr = 32'h40; imem_en = 1; imem_addr = 32'h08;
        @(negedge clk);
        nchk++; if (mem_hold !== 1'b1) begin nerr++; $display("FAIL cl_hold0 got %b want 1", mem_hold); end
        nchk++; if (ram_addr !== 12'd16) begin nerr++; $display("FAIL cl_addr0 got %0d want 16", ram_addr); end
        next_cycle();
        @(negedge clk);
        nchk++; if (mem_hold !== 1'b0) begin nerr++; $display("FAIL cl_hold1 got %b want 0", mem_hold); end
        nchk++; if (ram_addr !== 12'd2 || ram_en !== 1'b1) begin nerr++; $display("FAIL cl_addr1 got %0d/%b want 2/1", ram_addr, ram_en); end
        next_cycle(); idle();
        @(negedge clk);
        nchk++; if (imem_dout !== 32'h13) begin nerr++; $display("FAIL cl_imem got %h want 13", imem_dout); end
        nchk++; if (dmem_dout !== 32'hDEADBEEF) begin nerr++; $display("FAIL cl_dmem got %h want deadbeef", dmem_dout); end
        next_cycle();
    endtask

    task automatic test_conflict_store();
        dmem_wea = 1; dmem_en = 4'b0011; dmem_din = 32'hAAAA5555; dmem_addr = 32'h44;
        imem_en = 1; imem_addr = 32'h08;
        @(negedge clk);
        nchk++; if (ram_we !== 4'b0011 || mem_hold !== 1'b1) begin nerr++; $display("FAIL cs_we0 got %b/%b want 0011/1", ram_we, mem_hold); end
        next_cycle();
        @(negedge clk);
        nchk++; if (ram_we !== 4'b0000 || mem_hold !== 1'b0) begin nerr++; $display("FAIL cs_we1 got %b/%b want 0000/0", ram_we, mem_hold); end
        next_cycle(); idle();
        @(negedge clk);
        nchk++; if (mem[17] !== 32'h00005555) begin nerr++; $display("FAIL cs_ram got %h want 00005555", mem[17]); end
        nchk++; if (dmem_dout !== 32'hDEADBEEF) begin nerr++; $display("FAIL cs_dmem got %h want deadbeef", dmem_dout); end
        nchk++; if (imem_dout !== 32'h13) begin nerr++; $display("FAIL cs_imem got %h want 13", imem_dout); end
        next_cycle();
    endtask

    task automatic test_program();
        logic [31:0] v;
        prog_ena = 1;
        @(negedge clk);
        nchk++; if (mem_hold !== 1'b1 || ram_en !== 1'b0) begin nerr++; $display("FAIL pg_enter got %b/%b want 1/0", mem_hold, ram_en); end
        for (int k = 0; k < 3; k++) begin
            next_cycle(); prog_we = 1; v = 32'h11 * (k + 1); prog_din = v;
            @(negedge clk);
            nchk++; if (ram_en !== 1'b1 || ram_we !== 4'hF || ram_addr !== 12'(k) || mem_hold !== 1'b1)
                begin nerr++; $display("FAIL pg_wr%0d got en=%b we=%h a=%0d h=%b want 1 f %0d 1", k, ram_en, ram_we, ram_addr, mem_hold, k); end
            next_cycle(); prog_we = 0;
            @(negedge clk);
            nchk++; if (mem_hold !== 1'b1) begin nerr++; $display("FAIL pg_gap%0d hold got %b want 1", k, mem_hold); end
        end
        nchk++; if (prog_count !== 12'd3) begin nerr++; $display("FAIL pg_count got %0d want 3", prog_count); end
        nchk++; if (mem[0] !== 32'h11 || mem[1] !== 32'h22 || mem[2] !== 32'h33)
            begin nerr++; $display("FAIL pg_ram got %h %h %h want 11 22 33", mem[0], mem[1], mem[2]); end
        next_cycle(); prog_ena = 0;
        @(negedge clk);
        nchk++; if (mem_hold !== 1'b1 || ram_en !== 1'b0) begin nerr++; $display("FAIL pg_exit got %b/%b want 1/0", mem_hold, ram_en); end
        next_cycle();
        @(negedge clk);
        nchk++; if (prog_count !== 12'd0 || mem_hold !== 1'b0) begin nerr++; $display("FAIL pg_done got %0d/%b want 0/0", prog_count, mem_hold); end
        next_cycle();
    endtask

    task automatic test_wrap();
        p2_ena = 1;
        for (int k = 0; k < 5; k++) begin
            p2_we = 1; p2_din = 32'hA0 + k;
            @(negedge clk);
            nchk++; if (b_ram_en !== 1'b1 || b_ram_addr !== 2'(k % 4))
                begin nerr++; $display("FAIL wrap_addr%0d got %b/%0d want 1/%0d", k, b_ram_en, b_ram_addr, k % 4); end
            next_cycle();
        end
        p2_we = 0;
        @(negedge clk);
        nchk++; if (b_prog_count !== 2'd1) begin nerr++; $display("FAIL wrap_count got %0d want 1", b_prog_count); end
        nchk++; if (mem2[0] !== 32'hA4 || mem2[1] !== 32'hA1 || mem2[3] !== 32'hA3)
            begin nerr++; $display("FAIL wrap_ram got %h %h %h want a4 a1 a3", mem2[0], mem2[1], mem2[3]); end
        next_cycle(); p2_ena = 0;
        next_cycle();
    endtask

    task automatic test_reset_mid_fetch();
        dmem_rea = 1; dmem_en = 4'hF; dmem_addr = 32'h40; imem_en = 1; imem_addr = 32'h08;
        @(negedge clk);
        nchk++; if (mem_hold !== 1'b1) begin nerr++; $display("FAIL rmf_hold0 got %b want 1", mem_hold); end
        next_cycle(); Rst = 1;
        @(negedge clk);
        nchk++; if (ram_en !== 1'b0 || mem_hold !== 1'b0) begin nerr++; $display("FAIL rmf_abort got %b/%b want 0/0", ram_en, mem_hold); end
        next_cycle(); Rst = 0; idle();
        @(negedge clk);
        nchk++; if (imem_dout !== 32'h0 || dmem_dout !== 32'h0)
            begin nerr++; $display("FAIL rmf_outs got %h/%h want 0/0", imem_dout, dmem_dout); end
        nchk++; if (mem_hold !== 1'b0 || ram_en !== 1'b0) begin nerr++; $display("FAIL rmf_idle got %b/%b want 0/0", mem_hold, ram_en); end
        next_cycle();
        imem_en = 1; imem_addr = 32'h14;
        @(negedge clk);
        nchk++; if (mem_hold !== 1'b0 || ram_addr !== 12'd5) begin nerr++; $display("FAIL rmf_fetch got %b/%0d want 0/5", mem_hold, ram_addr); end
        next_cycle(); idle();
        @(negedge clk);
        nchk++; if (imem_dout !== 32'h00500093) begin nerr++; $display("FAIL rmf_data got %h want 00500093", imem_dout); end
        next_cycle();
    endtask

    task automatic test_random();
        logic [31:0] exp_i, exp_d, v;
        int fw, dw, op, holds, want_holds;
        logic do_f;
        Rst = 1; idle(); next_cycle(); Rst = 0;
        exp_i = 0; exp_d = 0;
        for (int i = 0; i < 32; i++) begin
            v = $urandom; mem[i] = v; ref_mem[i] = v;
        end
        for (int g = 0; g < 200; g++) begin
            do_f = 1'($urandom_range(0, 1));
            op = $urandom_range(0, 3);
            fw = $urandom_range(0, 31);
            dw = $urandom_range(0, 31);
            imem_en = do_f;
            imem_addr = ($urandom & 32'hFFFF_C003) | (32'(fw) << 2);
            dmem_addr = ($urandom & 32'hFFFF_C003) | (32'(dw) << 2);
            dmem_din = $urandom;
            dmem_rea = (op == 1 || op == 3);
            dmem_wea = (op == 2);
            dmem_en = (op == 3) ? 4'h0 : 4'($urandom_range(1, 15));
            // Data side of a transaction completes before its fetch.
            if (op == 1) exp_d = ref_mem[dw];
            if (op == 2)
                for (int b = 0; b < 4; b++)
                    if (dmem_en[b]) ref_mem[dw][8*b +: 8] = dmem_din[8*b +: 8];
            if (do_f) exp_i = ref_mem[fw];
            want_holds = (do_f && (op == 1 || op == 2)) ? 1 : 0;
            holds = 0;
            @(negedge clk);
            while (mem_hold === 1'b1 && holds < 4) begin
                holds++; next_cycle(); @(negedge clk);
            end
            nchk++; if (holds !== want_holds) begin nerr++; $display("FAIL rnd_holds g=%0d got %0d want %0d", g, holds, want_holds); end
            next_cycle(); idle();
            @(negedge clk);
            nchk++; if (imem_dout !== exp_i) begin nerr++; $display("FAIL rnd_imem g=%0d got %h want %h", g, imem_dout, exp_i); end
            nchk++; if (dmem_dout !== exp_d) begin nerr++; $display("FAIL rnd_dmem g=%0d got %h want %h", g, dmem_dout, exp_d); end
            next_cycle();
        end
    endtask

    initial begin
        for (int i = 0; i < 4096; i++) mem[i] = 32'h0;
        for (int i = 0; i < 4; i++) mem2[i] = 32'h0;
        mem[5] = 32'h00500093;
        mem[16] = 32'hDEADBEEF;
        mem[2] = 32'h13;
        Rst = 1; idle();
        #1;
        test_reset();
        test_fetch();
        test_conflict_load();
        test_conflict_store();
        test_program();
        test_wrap();
        test_reset_mid_fetch();
        test_random();
        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL timeout got no finish want finish");
        $fatal(1, "timeout");
    end

endmodule
